// File: rtl/alu_op_issue.sv
// Purpose: decode RV32I opcode/funct3/funct7 into an ALU Operation code and select SrcA/SrcB.
// Latency: 1 cycle from input accept to the outputs, through a registered main slot.
// Backpressure: 2-entry skid (main + skid); in_ready is registered and equals "skid empty".
module alu_op_issue #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPCODE_LENGTH  = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [6:0]                opcode,
  input  logic [2:0]                funct3,
  input  logic [6:0]                funct7,
  input  logic [DATA_WIDTH-1:0]     rs1_data,
  input  logic [DATA_WIDTH-1:0]     rs2_data,
  input  logic [DATA_WIDTH-1:0]     imm,
  input  logic [REG_ADDR_WIDTH-1:0] rd_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OPCODE_LENGTH-1:0]  Operation,
  output logic [DATA_WIDTH-1:0]     SrcA,
  output logic [DATA_WIDTH-1:0]     SrcB,
  output logic [REG_ADDR_WIDTH-1:0] rd_out,
  output logic                      is_branch,
  output logic                      illegal
);

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_STORE= 7'b0100011;
  localparam logic [6:0] OPC_BR   = 7'b1100011;
  localparam logic [6:0] OPC_LUI  = 7'b0110111;

  localparam logic [6:0] F7_ZERO  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;

  localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0110);
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
  localparam logic [OPCODE_LENGTH-1:0] OP_NE  = OPCODE_LENGTH'(4'b1110);
  localparam logic [OPCODE_LENGTH-1:0] OP_LT  = OPCODE_LENGTH'(4'b1111);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b0100);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(4'b0101);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(4'b0111);

  // One buffered instruction, as presented to EX.
  typedef struct packed {
    logic [OPCODE_LENGTH-1:0]  op;
    logic [DATA_WIDTH-1:0]     src_a;
    logic [DATA_WIDTH-1:0]     src_b;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      br;
    logic                      ill;
  } slot_t;

  slot_t dec_d;
  slot_t main_q;
  slot_t skid_q;
  logic  main_vld_q;
  logic  skid_vld_q;
  logic  in_ready_q;

  logic  push;
  logic  pop;

  // Decode the incoming instruction and pick its operands.
  always_comb begin
    dec_d       = '0;
    dec_d.op    = OP_AND;
    dec_d.rd    = rd_in;
    case (opcode)
      OPC_R: begin
        dec_d.src_a = rs1_data;
        dec_d.src_b = rs2_data;
        case (funct3)
          3'b000: begin
            if (funct7 == F7_ZERO)     dec_d.op  = OP_ADD;
            else if (funct7 == F7_ALT) dec_d.op  = OP_SUB;
            else                       dec_d.ill = 1'b1;
          end
          3'b111: begin dec_d.op = OP_AND; dec_d.ill = (funct7 != F7_ZERO); end
          3'b110: begin dec_d.op = OP_OR;  dec_d.ill = (funct7 != F7_ZERO); end
          3'b010: begin dec_d.op = OP_LT;  dec_d.ill = (funct7 != F7_ZERO); end
          3'b001: begin dec_d.op = OP_SLL; dec_d.ill = (funct7 != F7_ZERO); end
          3'b101: begin
            if (funct7 == F7_ZERO)     dec_d.op  = OP_SRL;
            else if (funct7 == F7_ALT) dec_d.op  = OP_SRA;
            else                       dec_d.ill = 1'b1;
          end
          default: dec_d.ill = 1'b1;
        endcase
      end
      OPC_I: begin
        dec_d.src_a = rs1_data;
        dec_d.src_b = imm;
        case (funct3)
          3'b000: dec_d.op = OP_ADD;
          3'b111: dec_d.op = OP_AND;
          3'b110: dec_d.op = OP_OR;
          3'b010: dec_d.op = OP_LT;
          3'b001: begin
            // Shift amount lives in imm[4:0]; the upper imm bits carry funct7.
            dec_d.src_b = {{(DATA_WIDTH-5){1'b0}}, imm[4:0]};
            dec_d.op    = OP_SLL;
            dec_d.ill   = (funct7 != F7_ZERO);
          end
          3'b101: begin
            dec_d.src_b = {{(DATA_WIDTH-5){1'b0}}, imm[4:0]};
            if (funct7 == F7_ZERO)     dec_d.op  = OP_SRL;
            else if (funct7 == F7_ALT) dec_d.op  = OP_SRA;
            else                       dec_d.ill = 1'b1;
          end
          default: dec_d.ill = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_STORE: begin
        dec_d.op    = OP_ADD;
        dec_d.src_a = rs1_data;
        dec_d.src_b = imm;
        if (opcode == OPC_STORE) dec_d.rd = '0;
      end
      OPC_BR: begin
        dec_d.src_a = rs1_data;
        dec_d.src_b = rs2_data;
        dec_d.br    = 1'b1;
        dec_d.rd    = '0;
        case (funct3)
          3'b000:  dec_d.op  = OP_EQ;
          3'b001:  dec_d.op  = OP_NE;
          3'b100:  dec_d.op  = OP_LT;
          default: dec_d.ill = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec_d.op    = OP_ADD;
        dec_d.src_b = imm;
      end
      default: dec_d.ill = 1'b1;
    endcase
    // Unsupported encodings leave a clean, harmless slot behind.
    if (dec_d.ill) begin
      dec_d.op    = OP_AND;
      dec_d.src_a = '0;
      dec_d.src_b = '0;
      dec_d.rd    = '0;
      dec_d.br    = 1'b0;
    end
  end

  assign push = in_valid && in_ready_q;
  assign pop  = main_vld_q && out_ready;

  // Main slot plus skid entry; flush wins over accept and drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else if (skid_vld_q) begin
      // in_ready is low here, so only a drain can make progress.
      if (pop) begin
        main_q     <= skid_q;
        skid_vld_q <= 1'b0;
        in_ready_q <= 1'b1;
      end
    end else if (push) begin
      if (!main_vld_q || pop) begin
        main_q     <= dec_d;
        main_vld_q <= 1'b1;
      end else begin
        skid_q     <= dec_d;
        skid_vld_q <= 1'b1;
        in_ready_q <= 1'b0;
      end
    end else if (pop) begin
      main_vld_q <= 1'b0;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_vld_q;
  assign Operation = main_q.op;
  assign SrcA      = main_q.src_a;
  assign SrcB      = main_q.src_b;
  assign rd_out    = main_q.rd;
  assign is_branch = main_q.br;
  assign illegal   = main_q.ill;

endmodule

// File: tb/tb_alu_op_issue.sv
module tb_alu_op_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic [4:0]  rd_in;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [4:0]  rd_out;
  logic        is_branch;
  logic        illegal;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  alu_op_issue #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .rd_in(rd_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB), .rd_out(rd_out),
    .is_branch(is_branch), .illegal(illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic [4:0] rd);
    in_valid = 1'b1;
    opcode   = opc;
    funct3   = f3;
    funct7   = f7;
    rs1_data = a;
    rs2_data = b;
    imm      = im;
    rd_in    = rd;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; funct3 = '0; funct7 = '0;
    rs1_data = '0; rs2_data = '0; imm = '0; rd_in = '0;
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_op",        32'(Operation), 32'd0);
    check("rst_srca",      SrcA,           32'd0);
    check("rst_srcb",      SrcB,           32'd0);
    check("rst_rd",        32'(rd_out),    32'd0);
    check("rst_branch",    32'(is_branch), 32'd0);
    check("rst_illegal",   32'(illegal),   32'd0);
    reset = 1'b0;
    out_ready = 1'b1;

    // R-type ADD
    offer(7'b0110011, 3'b000, 7'b0000000, 32'd5, 32'd7, 32'd0, 5'd3);
    step();
    check("add_vld",  32'(out_valid), 32'd1);
    check("add_op",   32'(Operation), 32'b0010);
    check("add_srca", SrcA,           32'd5);
    check("add_srcb", SrcB,           32'd7);
    check("add_rd",   32'(rd_out),    32'd3);

    // SRAI: shift amount from imm[4:0]
    offer(7'b0010011, 3'b101, 7'b0100000, 32'h8000_0000, 32'd0, 32'h0000_0403, 5'd4);
    step();
    check("srai_op",   32'(Operation), 32'b0111);
    check("srai_srca", SrcA,           32'h8000_0000);
    check("srai_srcb", SrcB,           32'd3);
    check("srai_ill",  32'(illegal),   32'd0);

    // BNE
    offer(7'b1100011, 3'b001, 7'b0000000, 32'd9, 32'd9, 32'h10, 5'd6);
    step();
    check("bne_op",   32'(Operation), 32'b1110);
    check("bne_br",   32'(is_branch), 32'd1);
    check("bne_rd",   32'(rd_out),    32'd0);
    check("bne_srcb", SrcB,           32'd9);

    // Unsupported opcode (FENCE)
    offer(7'b0001111, 3'b000, 7'b0000000, 32'd1, 32'd2, 32'd3, 5'd7);
    step();
    check("illop_ill",  32'(illegal),   32'd1);
    check("illop_op",   32'(Operation), 32'd0);
    check("illop_rd",   32'(rd_out),    32'd0);
    check("illop_srca", SrcA,           32'd0);

    // R-type SUB
    offer(7'b0110011, 3'b000, 7'b0100000, 32'd20, 32'd8, 32'd0, 5'd9);
    step();
    check("sub_op",  32'(Operation), 32'b0110);
    check("sub_ill", 32'(illegal),   32'd0);

    // LUI: SrcA forced to zero
    offer(7'b0110111, 3'b000, 7'b0000000, 32'hDEAD, 32'd0, 32'h1234_5000, 5'd10);
    step();
    check("lui_op",   32'(Operation), 32'b0010);
    check("lui_srca", SrcA,           32'd0);
    check("lui_srcb", SrcB,           32'h1234_5000);

    // Store: rd forced to zero
    offer(7'b0100011, 3'b010, 7'b0000000, 32'h100, 32'h55, 32'hFFFF_FFFC, 5'd11);
    step();
    check("sw_op",   32'(Operation), 32'b0010);
    check("sw_srcb", SrcB,           32'hFFFF_FFFC);
    check("sw_rd",   32'(rd_out),    32'd0);

    // Load keeps rd
    offer(7'b0000011, 3'b010, 7'b0000000, 32'h200, 32'd0, 32'd8, 5'd12);
    step();
    check("lw_rd",   32'(rd_out), 32'd12);
    check("lw_srca", SrcA,        32'h200);

    // R-type f3=000 with bad funct7
    offer(7'b0110011, 3'b000, 7'b0000001, 32'd1, 32'd1, 32'd0, 5'd1);
    step();
    check("rbad_ill", 32'(illegal),   32'd1);
    check("rbad_op",  32'(Operation), 32'd0);

    // I-type f3=100 (XORI) unsupported
    offer(7'b0010011, 3'b100, 7'b0000000, 32'd1, 32'd0, 32'd1, 5'd1);
    step();
    check("xori_ill", 32'(illegal), 32'd1);

    // SLTI maps to LT
    offer(7'b0010011, 3'b010, 7'b0000000, 32'd3, 32'd0, 32'hFFFF_FFFF, 5'd2);
    step();
    check("slti_op",   32'(Operation), 32'b1111);
    check("slti_srcb", SrcB,           32'hFFFF_FFFF);

    // BGE (f3=101) is not supported
    offer(7'b1100011, 3'b101, 7'b0000000, 32'd3, 32'd4, 32'd0, 5'd2);
    step();
    check("bge_ill", 32'(illegal),   32'd1);
    check("bge_br",  32'(is_branch), 32'd0);

    in_valid = 1'b0;
    step();
    check("drain_vld", 32'(out_valid), 32'd0);

    // Stall and skid
    out_ready = 1'b0;
    offer(7'b0110011, 3'b000, 7'b0000000, 32'd1, 32'd2, 32'd0, 5'd1);
    step();
    check("sk1_vld", 32'(out_valid), 32'd1);
    check("sk1_rdy", 32'(in_ready),  32'd1);
    offer(7'b0110011, 3'b000, 7'b0100000, 32'd10, 32'd3, 32'd0, 5'd2);
    step();
    check("sk2_rdy",  32'(in_ready),  32'd0);
    check("sk2_op",   32'(Operation), 32'b0010);
    check("sk2_srca", SrcA,           32'd1);
    in_valid = 1'b0;
    step();
    check("hold_op",   32'(Operation), 32'b0010);
    check("hold_srcb", SrcB,           32'd2);
    check("hold_rd",   32'(rd_out),    32'd1);
    out_ready = 1'b1;
    step();
    check("sub_out_vld",  32'(out_valid), 32'd1);
    check("sub_out_op",   32'(Operation), 32'b0110);
    check("sub_out_srca", SrcA,           32'd10);
    check("sub_out_rdy",  32'(in_ready),  32'd1);
    step();
    check("sk_empty_vld", 32'(out_valid), 32'd0);

    // Main full, skid empty, flush with an acceptable offer
    out_ready = 1'b0;
    offer(7'b0110011, 3'b111, 7'b0000000, 32'd4, 32'd5, 32'd0, 5'd4);
    step();
    flush = 1'b1;
    offer(7'b0110011, 3'b110, 7'b0000000, 32'd6, 32'd7, 32'd0, 5'd5);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl1_vld", 32'(out_valid), 32'd0);
    check("fl1_rdy", 32'(in_ready),  32'd1);
    out_ready = 1'b1;
    step();
    check("fl1_drop", 32'(out_valid), 32'd0);

    // Both entries full, flush with in_valid high
    out_ready = 1'b0;
    offer(7'b0110011, 3'b000, 7'b0000000, 32'd1, 32'd1, 32'd0, 5'd1);
    step();
    offer(7'b0110011, 3'b000, 7'b0000000, 32'd2, 32'd2, 32'd0, 5'd2);
    step();
    check("full_rdy", 32'(in_ready), 32'd0);
    flush = 1'b1;
    offer(7'b0110011, 3'b001, 7'b0000000, 32'd3, 32'd3, 32'd0, 5'd3);
    step();
    flush = 1'b0;
    check("fl2_vld", 32'(out_valid), 32'd0);
    check("fl2_rdy", 32'(in_ready),  32'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("fl2_drop", 32'(out_valid), 32'd0);

    // Async reset mid-stall
    out_ready = 1'b0;
    offer(7'b0110011, 3'b000, 7'b0000000, 32'd7, 32'd8, 32'd0, 5'd7);
    step();
    offer(7'b0110011, 3'b000, 7'b0100000, 32'd9, 32'd1, 32'd0, 5'd8);
    step();
    in_valid = 1'b0;
    check("pre_rst_vld", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_vld",  32'(out_valid), 32'd0);
    check("arst_rdy",  32'(in_ready),  32'd1);
    check("arst_op",   32'(Operation), 32'd0);
    check("arst_srca", SrcA,           32'd0);
    check("arst_rd",   32'(rd_out),    32'd0);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    step();
    check("post_rst_vld", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
